demux_dispatch_ctrl: RTL and testbench

//   Dispatcher that shares one producer stream between two consumers through the 1-to-2 demux datapath.

---
 rtl/demux_dispatch_ctrl.sv | 120 ++++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// Single-entry dispatcher: captures producer words and steers each to out0/out1
// by destination bit or round-robin, with per-output saturating delivery counters.

// Saturating delivered-word counter for one output lane; clear beats increment.
module demux_dispatch_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  // count deliveries, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + 1'b1;
  end
endmodule

module demux_dispatch_ctrl #(
  parameter int MAX_WIDTH = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 clr_cnt,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAX_WIDTH-1:0] in_data,
  input  logic                 in_dest,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [MAX_WIDTH-1:0] out0_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [MAX_WIDTH-1:0] out1_data,
  output logic                 sel,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state, state_nxt;
  logic [MAX_WIDTH-1:0]        hold;
  logic                        rr_ptr;
  logic                        tgt_ready, capture, deliver, target;
  logic [1:0][CNT_WIDTH-1:0]   cnt_q;

  assign tgt_ready = sel ? out1_ready : out0_ready;
  assign target    = mode ? rr_ptr : in_dest;
  assign capture   = in_valid && in_ready;
  assign deliver   = (state == SEND) && tgt_ready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and handshake/output decode; outputs depend only on registered
  // state plus the consumer readies, so in_* never reaches the outputs directly
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b1;
    busy       = 1'b0;
    out0_valid = 1'b0;
    out1_valid = 1'b0;
    out0_data  = '0;
    out1_data  = '0;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        in_ready = tgt_ready;
        if (sel) begin
          out1_valid = 1'b1;
          out1_data  = hold;
        end else begin
          out0_valid = 1'b1;
          out0_data  = hold;
        end
        if (tgt_ready && !in_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // hold register, demux select and round-robin pointer update on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold   <= '0;
      sel    <= 1'b0;
      rr_ptr <= 1'b0;
    end else if (capture) begin
      hold <= in_data;
      sel  <= target;
      if (mode) rr_ptr <= ~rr_ptr;
    end
  end

  // one counter per output lane
  for (genvar g = 0; g < 2; g++) begin : g_cnt
    demux_dispatch_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (deliver && (sel == 1'(g))),
      .cnt   (cnt_q[g])
    );
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux_dispatch_ctrl;
  localparam int MW = 8;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode, clr_cnt, in_valid, in_dest, out0_ready, out1_ready;
  logic [MW-1:0] in_data;
  logic          in_ready, out0_valid, out1_valid, sel, busy;
  logic [MW-1:0] out0_data, out1_data;
  logic [CW-1:0] cnt0, cnt1;

  int vectors = 0;
  int errors  = 0;

  // model: one optional held word with its destination, rr pointer, counts
  bit       m_full;
  bit [7:0] m_word;
  bit       m_dst;
  bit       m_rr;
  int       m_cnt [2];

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(.MAX_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .sel(sel), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_word = 0; m_dst = 0; m_rr = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // wait to mid-cycle and compare every output against the model
  task automatic settle();
    bit tr;
    @(negedge clk);
    tr = m_dst ? out1_ready : out0_ready;
    chk("in_ready",   int'(in_ready),   int'(!m_full || tr));
    chk("out0_valid", int'(out0_valid), int'(m_full && !m_dst));
    chk("out1_valid", int'(out1_valid), int'(m_full && m_dst));
    chk("out0_data",  int'(out0_data),  (m_full && !m_dst) ? int'(m_word) : 0);
    chk("out1_data",  int'(out1_data),  (m_full && m_dst) ? int'(m_word) : 0);
    chk("busy",       int'(busy),       int'(m_full));
    if (m_full) chk("sel", int'(sel), int'(m_dst));
    chk("cnt0",       int'(cnt0),       m_cnt[0]);
    chk("cnt1",       int'(cnt1),       m_cnt[1]);
  endtask

  // apply the transfer rules for the current inputs and step past the edge
  task automatic adv();
    bit tr, dlv, acc;
    tr  = m_dst ? out1_ready : out0_ready;
    dlv = m_full && tr;
    acc = in_valid && (!m_full || tr);
    if (dlv && m_cnt[m_dst] < CMAX) m_cnt[m_dst]++;
    if (clr_cnt) begin m_cnt[0] = 0; m_cnt[1] = 0; end
    if (acc) begin
      m_word = in_data;
      m_dst  = mode ? m_rr : in_dest;
      if (mode) m_rr = !m_rr;
      m_full = 1;
    end else if (dlv) m_full = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [7:0] d, input bit ds);
    in_valid = v; in_data = d; in_dest = ds;
  endtask

  initial begin
    rst_n = 0; mode = 0; clr_cnt = 0; in_valid = 0; in_data = 0; in_dest = 0;
    out0_ready = 1; out1_ready = 1;
    model_reset();
    #2;
    chk("rst busy", int'(busy), 0);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst valids", int'({out0_valid, out1_valid}), 0);
    chk("rst cnt", int'({cnt0, cnt1}), 0);
    @(posedge clk); #1; rst_n = 1;

    // 1: routed by destination bit
    drive(1, 8'hA5, 0); settle(); adv();
    drive(1, 8'h3C, 1); settle();
    chk("t1 out0_data", int'(out0_data), 'hA5);
    chk("t1 out1_data idle", int'(out1_data), 0);
    adv();
    drive(0, 0, 0); settle();
    chk("t1 out1_data", int'(out1_data), 'h3C);
    chk("t1 out0_data idle", int'(out0_data), 0);
    adv();
    settle(); chk("t1 cnt0", int'(cnt0), 1); chk("t1 cnt1", int'(cnt1), 1);
    clr_cnt = 1; adv(); clr_cnt = 0;

    // 2: round-robin, back to back
    mode = 1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), 0); settle();
      chk("t2 in_ready", int'(in_ready), 1);
      if (i > 1) chk("t2 alt", int'(((i - 2) % 2) ? out1_data : out0_data), i - 1);
      adv();
    end
    drive(0, 0, 0); settle();
    chk("t2 last", int'(out1_data), 4);
    adv();
    settle(); chk("t2 cnt0", int'(cnt0), 2); chk("t2 cnt1", int'(cnt1), 2);
    adv();

    // 3: backpressure on out0
    mode = 0; out0_ready = 0;
    drive(1, 8'h77, 0); settle(); adv();
    drive(1, 8'h11, 0);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t3 hold", int'({out0_valid, out0_data, in_ready}), int'({1'b1, 8'h77, 1'b0}));
      adv();
    end
    out0_ready = 1; settle();
    chk("t3 release", int'(in_ready), 1);
    adv();
    drive(0, 0, 0); settle(); adv(); settle(); adv();

    // 4: saturation then clear racing a delivery
    clr_cnt = 1; settle(); adv(); clr_cnt = 0;
    for (int i = 0; i < 5; i++) begin drive(1, 8'(8'h50 + i), 1); settle(); adv(); end
    drive(0, 0, 0); settle(); adv();
    settle(); chk("t4 sat", int'(cnt1), 3); adv();
    drive(1, 8'h66, 1); settle(); adv();
    drive(0, 0, 0); clr_cnt = 1; settle();
    chk("t4 deliver", int'(out1_valid && out1_ready), 1);
    adv(); clr_cnt = 0;
    settle(); chk("t4 clr", int'(cnt1), 0); adv();

    // 5: async reset while holding 0xFF
    out0_ready = 0;
    drive(1, 8'hFF, 0); settle(); adv();
    drive(0, 0, 0); settle();
    rst_n = 0; #1;
    model_reset();
    chk("t5 outs", int'({out0_valid, out1_valid, out0_data, out1_data, busy}), 0);
    chk("t5 cnt", int'({cnt0, cnt1}), 0);
    @(posedge clk); #1; rst_n = 1; out0_ready = 1;
    settle(); chk("t5 in_ready", int'(in_ready), 1); adv();

    // 6: mode switch while a word with sel=1 is held
    mode = 1;
    drive(1, 8'h10, 0); settle(); adv();
    out1_ready = 0; drive(1, 8'h20, 0); settle(); adv();
    mode = 0; drive(0, 0, 0); settle();
    chk("t6 held", int'({sel, out1_valid, out1_data}), int'({1'b1, 1'b1, 8'h20}));
    adv();
    out1_ready = 1; drive(1, 8'h30, 0); settle(); adv();
    mode = 1; drive(1, 8'h40, 1); settle();
    chk("t6 dest", int'({out0_valid, out0_data}), int'({1'b1, 8'h30}));
    adv();
    drive(0, 0, 0); settle();
    chk("t6 rr", int'({out0_valid, out0_data}), int'({1'b1, 8'h40}));
    adv();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      clr_cnt    = ($urandom_range(0, 39) == 0);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom));
      settle();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
